// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared types and constants for the AHB instruction fetch unit
package msrv32_pkg;

    typedef enum logic [1:0] {
        F_IDLE = 2'b00,
        F_ADDR = 2'b01,
        F_DATA = 2'b10
    } fetch_state_e;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/msrv32_fetch_fifo.sv
// rtl/msrv32_fetch_fifo.sv - circular instruction queue with flush
// Push and pop may coincide at any occupancy; flush overrides both.
module msrv32_fetch_fifo
    import msrv32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       i_push,
    input  logic [ENTRY_W-1:0]         i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [ENTRY_W-1:0]         o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]      r_rd_ptr;
    logic [PW-1:0]      r_wr_ptr;
    logic [CW-1:0]      r_count;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // a pop frees the slot this push lands in, so full+pop+push is legal
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/msrv32_ifetch_ahb.sv
// rtl/msrv32_ifetch_ahb.sv - AHB-Lite instruction fetch with a small prefetch queue
// One outstanding transfer at a time; misaligned targets yield a faulting NOP entry.
module msrv32_ifetch_ahb
    import msrv32_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
    parameter int          QDEPTH       = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] iaddr_in,
    input  logic        flush_in,
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic [2:0]  hsize_out,
    output logic        hwrite_out,
    input  logic [31:0] hrdata_in,
    input  logic        hready_in,
    input  logic        hresp_in,
    output logic        ahb_ready_out,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc_out,
    output logic        instr_valid_out,
    input  logic        instr_ready_in,
    output logic        fetch_err_out
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int OW = CW + 1;

    fetch_state_e       r_state;
    fetch_state_e       w_state_next;
    logic [31:0]        r_addr;
    logic               r_load;
    logic               r_squash;
    logic               r_stuck;

    logic               w_misaligned;
    logic               w_addr_busy;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_beat_kept;
    logic [CW-1:0]      w_count;
    logic [OW-1:0]      w_occ_data;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;
    logic [ENTRY_W-1:0] w_head_bits;

    assign w_misaligned = (r_addr[1:0] != 2'b00);
    assign w_addr_busy  = (r_state == F_ADDR) && !w_misaligned;
    assign w_pop        = instr_ready_in && !w_empty;
    assign w_beat_kept  = !r_squash && !flush_in;
    // occupancy after a data beat completing this cycle
    assign w_occ_data   = {1'b0, w_count} + OW'(w_beat_kept) - OW'(w_pop);

    always_comb begin
        w_state_next       = r_state;
        w_push             = 1'b0;
        w_push_entry.instr = hrdata_in;
        w_push_entry.pc    = r_addr;
        w_push_entry.err   = hresp_in;
        case (r_state)
            F_IDLE: begin
                if (!flush_in && !r_load && !r_stuck && (w_count < CW'(QDEPTH))) begin
                    w_state_next = F_ADDR;
                end
            end
            F_ADDR: begin
                if (w_misaligned) begin
                    w_state_next = F_IDLE;
                    if (!flush_in) begin
                        w_push             = 1'b1;
                        w_push_entry.instr = NOP_INSTR;
                        w_push_entry.err   = 1'b1;
                    end
                end else if (hready_in) begin
                    w_state_next = F_DATA;
                end
            end
            F_DATA: begin
                if (hready_in) begin
                    w_push = w_beat_kept;
                    if (!flush_in && (w_occ_data < OW'(QDEPTH))) begin
                        w_state_next = F_ADDR;
                    end else begin
                        w_state_next = F_IDLE;
                    end
                end
            end
            default: w_state_next = F_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state  <= F_IDLE;
            r_addr   <= BOOT_ADDRESS;
            r_load   <= 1'b1;
            r_squash <= 1'b0;
            r_stuck  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_load  <= ahb_ready_out;
            // an address phase on the bus must hold its address until accepted
            if (r_load || (flush_in && !w_addr_busy)) begin
                r_addr <= iaddr_in;
            end
            if (flush_in && (w_addr_busy || ((r_state == F_DATA) && !hready_in))) begin
                r_squash <= 1'b1;
            end else if ((r_state == F_DATA) && hready_in) begin
                r_squash <= 1'b0;
            end
            if (flush_in) begin
                r_stuck <= 1'b0;
            end else if ((r_state == F_ADDR) && w_misaligned) begin
                r_stuck <= 1'b1;
            end
        end
    end

    msrv32_fetch_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (flush_in),
        .o_head      (w_head_bits),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    a_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_in)
        !(w_push && w_full && !w_pop));

    assign w_head          = fetch_entry_t'(w_head_bits);
    assign haddr_out       = r_addr;
    assign htrans_out      = w_addr_busy ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hsize_out       = HSIZE_WORD;
    assign hwrite_out      = 1'b0;
    assign ahb_ready_out   = w_addr_busy && hready_in;
    assign instr_out       = w_head.instr;
    assign instr_pc_out    = w_head.pc;
    assign instr_valid_out = !w_empty;
    assign fetch_err_out   = !w_empty && w_head.err;

endmodule

// File: tb/tb_msrv32_ifetch_ahb.sv
// tb/tb_msrv32_ifetch_ahb.sv - directed self-checking bench for msrv32_ifetch_ahb
module tb_msrv32_ifetch_ahb;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] iaddr_in;
    logic        flush_in;
    logic [31:0] haddr_out;
    logic [1:0]  htrans_out;
    logic [2:0]  hsize_out;
    logic        hwrite_out;
    logic [31:0] hrdata_in;
    logic        hready_in;
    logic        hresp_in;
    logic        ahb_ready_out;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        instr_valid_out;
    logic        instr_ready_in;
    logic        fetch_err_out;

    logic        pc_ovr;
    logic [31:0] pc_force;
    logic [31:0] pc_model;
    int          n_pulse;
    int          p0;
    int          n_checks = 0;
    int          n_fail   = 0;

    assign iaddr_in = pc_ovr ? pc_force : pc_model;

    msrv32_ifetch_ahb #(
        .BOOT_ADDRESS (32'h0000_0040),
        .QDEPTH       (2)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .iaddr_in        (iaddr_in),
        .flush_in        (flush_in),
        .haddr_out       (haddr_out),
        .htrans_out      (htrans_out),
        .hsize_out       (hsize_out),
        .hwrite_out      (hwrite_out),
        .hrdata_in       (hrdata_in),
        .hready_in       (hready_in),
        .hresp_in        (hresp_in),
        .ahb_ready_out   (ahb_ready_out),
        .instr_out       (instr_out),
        .instr_pc_out    (instr_pc_out),
        .instr_valid_out (instr_valid_out),
        .instr_ready_in  (instr_ready_in),
        .fetch_err_out   (fetch_err_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0000_0093 : (32'hC0DE_0000 | {16'h0, a[15:0]});
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #4;
    endtask

    // memory slave and PC stage: act at negedge, away from DUT edges
    initial begin
        pc_model  = 32'h0;
        hrdata_in = 32'h0;
        n_pulse   = 0;
        forever begin
            @(negedge clk_in);
            if (htrans_out == 2'b10 && hready_in) hrdata_in = mem_word(haddr_out);
            if (ahb_ready_out) begin
                pc_model = haddr_out + 32'd4;
                n_pulse++;
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not reach the end of the sequence");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in = 1'b0; hready_in = 1'b1; hresp_in = 1'b0; flush_in = 1'b0;
        instr_ready_in = 1'b0; pc_ovr = 1'b0; pc_force = 32'h0;
        repeat (2) @(posedge clk_in);
        #4;
        check("rst_htrans", 32'(htrans_out), 32'h0);
        check("rst_haddr", haddr_out, 32'h40);
        check("rst_ahb_ready", 32'(ahb_ready_out), 32'h0);
        check("rst_valid", 32'(instr_valid_out), 32'h0);
        check("rst_instr", instr_out, 32'h0);
        check("rst_pc", instr_pc_out, 32'h0);
        check("rst_err", 32'(fetch_err_out), 32'h0);
        check("hsize", 32'(hsize_out), 32'h2);
        check("hwrite", 32'(hwrite_out), 32'h0);
        @(posedge clk_in); #1; rst_in = 1'b1; #3;

        tick(); check("e1_htrans", 32'(htrans_out), 32'h0);
        tick(); check("e2_htrans", 32'(htrans_out), 32'h2);
        check("e2_haddr", haddr_out, 32'h0);
        check("e2_ahb_ready", 32'(ahb_ready_out), 32'h1);
        tick(); check("e3_valid", 32'(instr_valid_out), 32'h0);
        check("e3_htrans", 32'(htrans_out), 32'h0);
        tick(); check("e4_valid", 32'(instr_valid_out), 32'h1);
        check("e4_instr", instr_out, 32'h0000_0093);
        check("e4_pc", instr_pc_out, 32'h0);
        check("e4_err", 32'(fetch_err_out), 32'h0);
        check("e4_htrans", 32'(htrans_out), 32'h2);
        check("e4_haddr", haddr_out, 32'h4);

        tick(); tick(); check("full_htrans_a", 32'(htrans_out), 32'h0);
        check("full_head_pc", instr_pc_out, 32'h0);
        tick(); check("full_htrans_b", 32'(htrans_out), 32'h0);
        tick(); check("full_htrans_c", 32'(htrans_out), 32'h0);
        check("full_valid", 32'(instr_valid_out), 32'h1);
        instr_ready_in = 1'b1;
        @(posedge clk_in); #1; instr_ready_in = 1'b0; #3;
        check("pop_pc", instr_pc_out, 32'h4);
        check("pop_instr", instr_out, 32'hC0DE_0004);
        check("pop_htrans", 32'(htrans_out), 32'h0);
        tick(); check("refill_htrans", 32'(htrans_out), 32'h2);
        check("refill_haddr", haddr_out, 32'h8);
        instr_ready_in = 1'b1;

        @(posedge clk_in); #1; hresp_in = 1'b1; #3;
        check("err_dphase_valid", 32'(instr_valid_out), 32'h0);
        @(posedge clk_in); #1; hresp_in = 1'b0; #3;
        check("err_valid", 32'(instr_valid_out), 32'h1);
        check("err_pc", instr_pc_out, 32'h8);
        check("err_flag", 32'(fetch_err_out), 32'h1);
        check("err_instr", instr_out, 32'hC0DE_0008);
        check("err_next_htrans", 32'(htrans_out), 32'h2);
        check("err_next_haddr", haddr_out, 32'hC);
        tick(); check("e13_valid", 32'(instr_valid_out), 32'h0);

        @(posedge clk_in); #1; hready_in = 1'b0; instr_ready_in = 1'b0; #3;
        p0 = n_pulse;
        for (int i = 0; i < 3; i++) begin
            check("wait_htrans", 32'(htrans_out), 32'h2);
            check("wait_haddr", haddr_out, 32'h10);
            check("wait_ahb_ready", 32'(ahb_ready_out), 32'h0);
            if (i < 2) tick();
        end
        @(posedge clk_in); #1; hready_in = 1'b1; #3;
        check("accept_ahb_ready", 32'(ahb_ready_out), 32'h1);
        check("accept_haddr", haddr_out, 32'h10);

        @(posedge clk_in); #1; hready_in = 1'b0; flush_in = 1'b1; pc_ovr = 1'b1; pc_force = 32'h100; #3;
        check("single_pulse", 32'(n_pulse - p0), 32'h1);
        check("preflush_valid", 32'(instr_valid_out), 32'h1);
        check("preflush_pc", instr_pc_out, 32'hC);
        @(posedge clk_in); #1; flush_in = 1'b0; pc_ovr = 1'b0; #3;
        check("flush_valid", 32'(instr_valid_out), 32'h0);
        check("flush_htrans", 32'(htrans_out), 32'h0);
        @(posedge clk_in); #1; hready_in = 1'b1; #3;
        check("squash_valid", 32'(instr_valid_out), 32'h0);
        tick(); check("redir_htrans", 32'(htrans_out), 32'h2);
        check("redir_haddr", haddr_out, 32'h100);
        tick(); tick();
        check("redir_valid", 32'(instr_valid_out), 32'h1);
        check("redir_pc", instr_pc_out, 32'h100);
        check("redir_instr", instr_out, 32'hC0DE_0100);

        @(posedge clk_in); #1; rst_in = 1'b0; pc_ovr = 1'b1; pc_force = 32'h102; #3;
        check("midrst_valid", 32'(instr_valid_out), 32'h0);
        check("midrst_htrans", 32'(htrans_out), 32'h0);
        check("midrst_haddr", haddr_out, 32'h40);
        @(posedge clk_in); #1; rst_in = 1'b1; #3;
        tick(); check("mis_e1_htrans", 32'(htrans_out), 32'h0);
        check("mis_e1_haddr", haddr_out, 32'h102);
        tick(); check("mis_e2_htrans", 32'(htrans_out), 32'h0);
        check("mis_e2_ahb_ready", 32'(ahb_ready_out), 32'h0);
        tick(); check("mis_valid", 32'(instr_valid_out), 32'h1);
        check("mis_instr", instr_out, 32'h0000_0013);
        check("mis_pc", instr_pc_out, 32'h102);
        check("mis_err", 32'(fetch_err_out), 32'h1);
        check("mis_htrans", 32'(htrans_out), 32'h0);
        @(posedge clk_in); #1; instr_ready_in = 1'b1; #3;
        check("stuck_htrans_a", 32'(htrans_out), 32'h0);
        @(posedge clk_in); #1; instr_ready_in = 1'b0; flush_in = 1'b1; pc_force = 32'h200; #3;
        check("stuck_valid", 32'(instr_valid_out), 32'h0);
        check("stuck_htrans_b", 32'(htrans_out), 32'h0);
        @(posedge clk_in); #1; flush_in = 1'b0; #3;
        check("recover_haddr", haddr_out, 32'h200);
        check("recover_idle", 32'(htrans_out), 32'h0);
        tick(); check("recover_htrans", 32'(htrans_out), 32'h2);
        check("recover_haddr2", haddr_out, 32'h200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
